// File: rtl/mips_pkg.sv
// Shared MIPS definitions: PC source encodings, instruction field positions, opcodes.
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALURES = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int JADDR_MSB = 25;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-high reset to a parameterised value.
module flopenr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   r_q <= RESET_VAL;
    else if (en) r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Multicycle MIPS fetch stage: PC, IR and MDR, address mux and field decode.
// Optional fetched-instruction counter built only when INSTR_CNT_EN is defined.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCEn,
  input  logic [1:0]       PCSrc,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] ReadData,
  input  logic             mem_rdy,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] Data,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic             stall,
  output logic [31:0]      icount
);

  logic [WIDTH-1:0] w_pc;
  logic [WIDTH-1:0] w_instr;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_jump;
  logic             w_stall;
  logic             w_ir_en;
  logic             w_pc_en;

  assign w_stall = IRWrite & ~mem_rdy;
  assign w_ir_en = IRWrite & mem_rdy;
  assign w_pc_en = PCEn & ~w_stall;

  // Jump target is formed from the IR as it stands before this edge.
  assign w_jump = {w_pc[WIDTH-1:WIDTH-4], w_instr[JADDR_MSB:0], 2'b00};

  always_comb begin
    w_pc_next = w_pc;
    case (pcsrc_e'(PCSrc))
      PCSRC_ALURES: w_pc_next = ALUResult;
      PCSRC_ALUOUT: w_pc_next = ALUOut;
      PCSRC_JUMP:   w_pc_next = w_jump;
      default:      w_pc_next = w_pc;
    endcase
  end

  flopenr #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(w_pc_en), .d(w_pc_next), .q(w_pc)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
    .clk(clk), .reset(reset), .en(w_ir_en), .d(ReadData), .q(w_instr)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mdr (
    .clk(clk), .reset(reset), .en(mem_rdy), .d(ReadData), .q(w_data)
  );

`ifdef INSTR_CNT_EN
  logic [31:0] r_icount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_icount <= '0;
    else if (w_ir_en) r_icount <= r_icount + 32'd1;
  end

  assign icount = r_icount;
`else
  assign icount = '0;
`endif

  assign Adr   = IorD ? ALUOut : w_pc;
  assign PC    = w_pc;
  assign Instr = w_instr;
  assign Data  = w_data;
  assign stall = w_stall;
  assign op    = w_instr[OP_MSB:OP_LSB];
  assign funct = w_instr[FUNCT_MSB:FUNCT_LSB];
  assign rs    = w_instr[RS_MSB:RS_LSB];
  assign rt    = w_instr[RT_MSB:RT_LSB];
  assign rd    = w_instr[RD_MSB:RD_LSB];
  assign imm   = w_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; icount expectation follows INSTR_CNT_EN.
module tb_fetch_unit;

`ifdef INSTR_CNT_EN
  localparam logic [31:0] EXP_CNT = 32'd5;
`else
  localparam logic [31:0] EXP_CNT = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset = 1'b0;
  logic        PCEn = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic        IorD = 1'b0;
  logic        IRWrite = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] ALUOut = '0;
  logic [31:0] ReadData = '0;
  logic        mem_rdy = 1'b0;
  logic [31:0] Adr, PC, Instr, Data, icount;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;

  always #5 if (clk_en) clk = ~clk;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCEn(PCEn), .PCSrc(PCSrc), .IorD(IorD),
    .IRWrite(IRWrite), .ALUResult(ALUResult), .ALUOut(ALUOut),
    .ReadData(ReadData), .mem_rdy(mem_rdy), .Adr(Adr), .PC(PC),
    .Instr(Instr), .Data(Data), .op(op), .funct(funct), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .stall(stall), .icount(icount)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", PC, 32'h0); end
    vectors++; if (Instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want %h", Instr, 32'h0); end
    vectors++; if (Data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want %h", Data, 32'h0); end
    vectors++; if (Adr !== 32'h0) begin miscompares++; $display("FAIL reset_adr got %h want %h", Adr, 32'h0); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall); end
    vectors++; if (icount !== 32'h0) begin miscompares++; $display("FAIL reset_icount got %0d want 0", icount); end
    vectors++; if ({op, funct, rs, rt, rd, imm} !== '0) begin miscompares++; $display("FAIL reset_fields got op=%h funct=%h imm=%h want 0", op, funct, imm); end
    #2 reset = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    IRWrite = 1'b1; PCEn = 1'b1; PCSrc = 2'b00; mem_rdy = 1'b1; IorD = 1'b0;
    ReadData = 32'h8C08_0004; ALUResult = 32'd4;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL fetch_stall got %b want 0", stall); end
    step();
    vectors++; if (Instr !== 32'h8C08_0004) begin miscompares++; $display("FAIL fetch_instr got %h want %h", Instr, 32'h8C08_0004); end
    vectors++; if (op !== 6'h23) begin miscompares++; $display("FAIL fetch_op got %h want 23", op); end
    vectors++; if (rt !== 5'd8) begin miscompares++; $display("FAIL fetch_rt got %0d want 8", rt); end
    vectors++; if (imm !== 16'd4) begin miscompares++; $display("FAIL fetch_imm got %h want 0004", imm); end
    vectors++; if (rs !== 5'd0) begin miscompares++; $display("FAIL fetch_rs got %0d want 0", rs); end
    vectors++; if (PC !== 32'd4) begin miscompares++; $display("FAIL fetch_pc got %h want %h", PC, 32'd4); end
    vectors++; if (Data !== 32'h8C08_0004) begin miscompares++; $display("FAIL fetch_mdr got %h want %h", Data, 32'h8C08_0004); end
  endtask

  task automatic test_stall();
    ReadData = 32'h2008_0005; ALUResult = 32'd8; mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL stall_flag[%0d] got %b want 1", i, stall); end
      step();
      vectors++; if (PC !== 32'd4) begin miscompares++; $display("FAIL stall_pc[%0d] got %h want %h", i, PC, 32'd4); end
      vectors++; if (Instr !== 32'h8C08_0004) begin miscompares++; $display("FAIL stall_instr[%0d] got %h want %h", i, Instr, 32'h8C08_0004); end
      vectors++; if (Data !== 32'h8C08_0004) begin miscompares++; $display("FAIL stall_mdr[%0d] got %h want %h", i, Data, 32'h8C08_0004); end
    end
    mem_rdy = 1'b1;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL stall_release got %b want 0", stall); end
    step();
    vectors++; if (PC !== 32'd8) begin miscompares++; $display("FAIL stall_pc_adv got %h want %h", PC, 32'd8); end
    vectors++; if (Instr !== 32'h2008_0005) begin miscompares++; $display("FAIL stall_instr_ld got %h want %h", Instr, 32'h2008_0005); end
    vectors++; if (op !== 6'h08) begin miscompares++; $display("FAIL stall_op got %h want 08", op); end
  endtask

  task automatic test_jump();
    // Load PC=A0000008 via ALUOut and IR=j 0x10 on the same edge.
    PCSrc = 2'b01; ALUOut = 32'hA000_0008; PCEn = 1'b1; IRWrite = 1'b1;
    mem_rdy = 1'b1; ReadData = 32'h0800_0010;
    step();
    vectors++; if (PC !== 32'hA000_0008) begin miscompares++; $display("FAIL jump_setup_pc got %h want %h", PC, 32'hA000_0008); end
    vectors++; if (op !== 6'h02) begin miscompares++; $display("FAIL jump_op got %h want 02", op); end
    // Jump while loading a different IR: target must come from the old IR.
    PCSrc = 2'b10; ReadData = 32'h0800_0020;
    step();
    vectors++; if (PC !== 32'hA000_0040) begin miscompares++; $display("FAIL jump_pc got %h want %h", PC, 32'hA000_0040); end
    vectors++; if (Instr !== 32'h0800_0020) begin miscompares++; $display("FAIL jump_new_ir got %h want %h", Instr, 32'h0800_0020); end
    IRWrite = 1'b0; PCSrc = 2'b11; ALUResult = 32'hFFFF_FFFF;
    step();
    vectors++; if (PC !== 32'hA000_0040) begin miscompares++; $display("FAIL jump_hold_src got %h want %h", PC, 32'hA000_0040); end
    PCEn = 1'b0; PCSrc = 2'b00;
    step();
    vectors++; if (PC !== 32'hA000_0040) begin miscompares++; $display("FAIL pcen_low got %h want %h", PC, 32'hA000_0040); end
    PCEn = 1'b1;
    step();
    vectors++; if (PC !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL pc_unaligned got %h want %h", PC, 32'hFFFF_FFFF); end
    PCEn = 1'b0;
  endtask

  task automatic test_iord_mdr();
    IorD = 1'b1; ALUOut = 32'h0000_0100; mem_rdy = 1'b1; ReadData = 32'hDEAD_BEEF;
    #1;
    vectors++; if (Adr !== 32'h0000_0100) begin miscompares++; $display("FAIL iord_adr got %h want %h", Adr, 32'h100); end
    step();
    vectors++; if (Data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mdr_load got %h want %h", Data, 32'hDEAD_BEEF); end
    vectors++; if (Instr !== 32'h0800_0020) begin miscompares++; $display("FAIL mdr_ir_hold got %h want %h", Instr, 32'h0800_0020); end
    mem_rdy = 1'b0; ReadData = 32'h1234_5678;
    step();
    vectors++; if (Data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mdr_hold got %h want %h", Data, 32'hDEAD_BEEF); end
    IorD = 1'b0;
    #1;
    vectors++; if (Adr !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL iord_pc got %h want %h", Adr, 32'hFFFF_FFFF); end
  endtask

  task automatic test_icount_reset();
    IRWrite = 1'b1; mem_rdy = 1'b1; ReadData = 32'h0000_0020; PCEn = 1'b0;
    step();
    vectors++; if (icount !== EXP_CNT) begin miscompares++; $display("FAIL icount got %0d want %0d", icount, EXP_CNT); end
    mem_rdy = 1'b0; PCEn = 1'b1; ALUResult = 32'h0000_0044;
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL prereset_stall got %b want 1", stall); end
    step();
    // Reset mid-cycle; control also resets, so IRWrite/PCEn drop with it.
    #2 reset = 1'b1; IRWrite = 1'b0; PCEn = 1'b0;
    #1;
    vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL midreset_pc got %h want %h", PC, 32'h0); end
    vectors++; if (Instr !== 32'h0) begin miscompares++; $display("FAIL midreset_instr got %h want %h", Instr, 32'h0); end
    vectors++; if (Data !== 32'h0) begin miscompares++; $display("FAIL midreset_data got %h want %h", Data, 32'h0); end
    vectors++; if (icount !== 32'h0) begin miscompares++; $display("FAIL midreset_icount got %0d want 0", icount); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL midreset_stall got %b want 0", stall); end
    step();
    reset = 1'b0;
    step();
    vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL postreset_pc got %h want %h", PC, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_jump();
    test_iord_mdr();
    test_icount_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
